// File: rtl/cell_test_pkg.sv
// Shared types and constants for the standard-cell functional test sequencer.
package cell_test_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Expected cell function encodings carried on Mode
    localparam logic [1:0] MODE_INV  = 2'b00;
    localparam logic [1:0] MODE_NAND = 2'b01;
    localparam logic [1:0] MODE_NOR  = 2'b10;
    localparam logic [1:0] MODE_XOR  = 2'b11;

    // Mismatch counter ceiling
    localparam logic [7:0] ERR_MAX = 8'd255;

    // Increment that sticks at ERR_MAX instead of wrapping to zero
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == ERR_MAX) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cell_model.sv
// Combinational reference of the cell under test: expected Y for a pattern and mode.
module cell_model
    import cell_test_pkg::*;
#(
    parameter int N_IN = 1
) (
    input  logic [N_IN-1:0] stim,
    input  logic [1:0]      mode,
    output logic            y
);

    // Select the logic function named by mode and evaluate it over the pattern
    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_INV:  y = ~stim[0];
            MODE_NAND: y = ~(&stim);
            MODE_NOR:  y = ~(|stim);
            MODE_XOR:  y = ^stim;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/cell_test_seq.sv
// Exhaustive functional test sequencer for a single standard cell.
// Walks every input pattern, waits SETTLE cycles for the cell to settle,
// then compares the cell response against the expected function.
module cell_test_seq
    import cell_test_pkg::*;
#(
    parameter int N_IN   = 1,
    parameter int SETTLE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Abort,
    input  logic [1:0]      Mode,
    input  logic            Resp,
    output logic [N_IN-1:0] Stim,
    output logic            Busy,
    output logic            Done,
    output logic            Pass,
    output logic [7:0]      ErrCount,
    output logic [N_IN-1:0] FirstFail
);

    // Counter only has to hold SETTLE-1, so SETTLE=1 still needs one bit
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  STIM_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]  STIM_ONE  = N_IN'(1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [N_IN-1:0] stim_r;
    logic [N_IN-1:0] stim_nxt_s;
    logic [7:0]      err_r;
    logic [7:0]      err_nxt_s;
    logic [N_IN-1:0] ff_r;
    logic [N_IN-1:0] ff_nxt_s;
    logic            done_r;
    logic            done_nxt_s;
    logic            busy_r;
    logic            busy_nxt_s;
    logic            pass_r;
    logic            pass_nxt_s;
    logic [1:0]      mode_r;
    logic [1:0]      mode_nxt_s;
    logic            expected_s;

    // Expected response uses the mode captured at Start, never the live input
    cell_model #(
        .N_IN (N_IN)
    ) u_cell_model (
        .stim (stim_r),
        .mode (mode_r),
        .y    (expected_s)
    );

    // Next-state and next-output decode of the test sequence
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stim_nxt_s  = stim_r;
        err_nxt_s   = err_r;
        ff_nxt_s    = ff_r;
        done_nxt_s  = done_r;
        mode_nxt_s  = mode_r;

        case (state_r)
            ST_IDLE: begin
                // Start wins over a simultaneous Abort; Done holds otherwise
                if (Start) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_LOAD;
                    stim_nxt_s  = STIM_ZERO;
                    err_nxt_s   = 8'd0;
                    ff_nxt_s    = STIM_ZERO;
                    done_nxt_s  = 1'b0;
                    mode_nxt_s  = Mode;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (Abort) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b0;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end

            ST_SAMPLE: begin
                if (Abort) begin
                    // Partial results are kept for inspection
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b0;
                end else begin
                    if (Resp != expected_s) begin
                        if (err_r == 8'd0) begin
                            ff_nxt_s = stim_r;
                        end else begin
                            ff_nxt_s = ff_r;
                        end
                        err_nxt_s = sat_inc(err_r);
                    end else begin
                        err_nxt_s = err_r;
                    end

                    if (&stim_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        // Stim only moves here, so it is steady through settle and sample
                        stim_nxt_s  = stim_r + STIM_ONE;
                        cnt_nxt_s   = CNT_LOAD;
                        state_nxt_s = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next-state view so they line up with state
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        pass_nxt_s = done_nxt_s && (err_nxt_s == 8'd0);
    end

    // State and result registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            stim_r  <= STIM_ZERO;
            err_r   <= 8'd0;
            ff_r    <= STIM_ZERO;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            pass_r  <= 1'b0;
            mode_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            stim_r  <= stim_nxt_s;
            err_r   <= err_nxt_s;
            ff_r    <= ff_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
            pass_r  <= pass_nxt_s;
            mode_r  <= mode_nxt_s;
        end
    end

    assign Stim      = stim_r;
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Pass      = pass_r;
    assign ErrCount  = err_r;
    assign FirstFail = ff_r;

endmodule

// File: tb/tb_cell_test_seq.sv
// Self-checking bench: three sequencers (N_IN = 1, 2, 4) share control inputs,
// each driven by its own emulated cell, and are compared every cycle against
// a cycle-count based model of the test run.
module tb_cell_test_seq;
    import cell_test_pkg::*;

    localparam int S = 4;
    localparam int N_OF [3] = '{1, 2, 4};

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Start = 1'b0;
    logic Abort = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic [1:0] cell_mode = 2'b00;

    // 0 = healthy cell, 1 = stuck at 1, 2 = stuck at 0, 3 = inverted output
    int resp_sel [3] = '{0, 0, 0};

    logic [2:0] resp_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [7:0] err_a [3];
    logic [0:0] stim1;
    logic [1:0] stim2;
    logic [3:0] stim4;
    logic [0:0] ff1;
    logic [1:0] ff2;
    logic [3:0] ff4;
    logic [3:0] stim_a [3];
    logic [3:0] ff_a [3];

    logic [3:0] cm_stim = 4'd0;
    logic [1:0] cm_mode = 2'd0;
    logic       cm_y;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 Clock = ~Clock;

    cell_test_seq #(.N_IN(1), .SETTLE(S)) u1 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
        .Resp(resp_v[0]), .Stim(stim1), .Busy(busy_v[0]), .Done(done_v[0]),
        .Pass(pass_v[0]), .ErrCount(err_a[0]), .FirstFail(ff1));

    cell_test_seq #(.N_IN(2), .SETTLE(S)) u2 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
        .Resp(resp_v[1]), .Stim(stim2), .Busy(busy_v[1]), .Done(done_v[1]),
        .Pass(pass_v[1]), .ErrCount(err_a[1]), .FirstFail(ff2));

    cell_test_seq #(.N_IN(4), .SETTLE(S)) u4 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Mode(Mode),
        .Resp(resp_v[2]), .Stim(stim4), .Busy(busy_v[2]), .Done(done_v[2]),
        .Pass(pass_v[2]), .ErrCount(err_a[2]), .FirstFail(ff4));

    cell_model #(.N_IN(4)) u_cm (.stim(cm_stim), .mode(cm_mode), .y(cm_y));

    assign stim_a[0] = {3'b000, stim1};
    assign stim_a[1] = {2'b00, stim2};
    assign stim_a[2] = stim4;
    assign ff_a[0]   = {3'b000, ff1};
    assign ff_a[1]   = {2'b00, ff2};
    assign ff_a[2]   = ff4;

    // Cell truth from counting ones among the n driven inputs
    function automatic logic golden(input logic [1:0] m, input logic [3:0] s, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(s[i]);
        case (m)
            2'b00:   return ~s[0];
            2'b01:   return (ones != n);
            2'b10:   return (ones == 0);
            default: return ((ones % 2) == 1);
        endcase
    endfunction

    function automatic logic cell_out(input int sel, input logic [1:0] m, input logic [3:0] s, input int n);
        case (sel)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~golden(m, s, n);
            default: return golden(m, s, n);
        endcase
    endfunction

    // Emulated cells under test
    always_comb begin
        resp_v[0] = cell_out(resp_sel[0], cell_mode, stim_a[0], N_OF[0]);
        resp_v[1] = cell_out(resp_sel[1], cell_mode, stim_a[1], N_OF[1]);
        resp_v[2] = cell_out(resp_sel[2], cell_mode, stim_a[2], N_OF[2]);
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Run model: k counts edges since the Start edge; every (S+1)th edge is a sample,
    // the edge after the last sample raises Done.
    bit         m_act  [3] = '{0, 0, 0};
    int         m_k    [3] = '{0, 0, 0};
    logic [3:0] m_stim [3] = '{4'd0, 4'd0, 4'd0};
    int         m_err  [3] = '{0, 0, 0};
    logic [3:0] m_ff   [3] = '{4'd0, 4'd0, 4'd0};
    bit         m_done [3] = '{0, 0, 0};
    logic [1:0] m_mode [3] = '{2'd0, 2'd0, 2'd0};

    always @(posedge Clock) begin
        for (int d = 0; d < 3; d++) begin
            if (Reset) begin
                m_act[d]  <= 1'b0;
                m_k[d]    <= 0;
                m_stim[d] <= 4'd0;
                m_err[d]  <= 0;
                m_ff[d]   <= 4'd0;
                m_done[d] <= 1'b0;
            end else if (!m_act[d]) begin
                if (Start) begin
                    m_act[d]  <= 1'b1;
                    m_k[d]    <= 0;
                    m_stim[d] <= 4'd0;
                    m_err[d]  <= 0;
                    m_ff[d]   <= 4'd0;
                    m_done[d] <= 1'b0;
                    m_mode[d] <= Mode;
                end
            end else if (Abort && (m_k[d] < (1 << N_OF[d]) * (S + 1))) begin
                m_act[d] <= 1'b0;
            end else begin
                m_k[d] <= m_k[d] + 1;
                if (m_k[d] + 1 == (1 << N_OF[d]) * (S + 1) + 1) begin
                    m_act[d]  <= 1'b0;
                    m_done[d] <= 1'b1;
                end else if (((m_k[d] + 1) % (S + 1)) == 0) begin
                    if (resp_v[d] != golden(m_mode[d], m_stim[d], N_OF[d])) begin
                        if (m_err[d] == 0) m_ff[d] <= m_stim[d];
                        if (m_err[d] < 255) m_err[d] <= m_err[d] + 1;
                    end
                    if (m_k[d] + 1 < (1 << N_OF[d]) * (S + 1)) m_stim[d] <= m_stim[d] + 4'd1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every sequencer against the model
    always @(negedge Clock) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("busy[%0d]", d), int'(busy_v[d]), int'(m_act[d]));
                check($sformatf("done[%0d]", d), int'(done_v[d]), int'(m_done[d]));
                check($sformatf("pass[%0d]", d), int'(pass_v[d]), int'(m_done[d] && (m_err[d] == 0)));
                check($sformatf("err[%0d]", d), int'(err_a[d]), m_err[d]);
                check($sformatf("stim[%0d]", d), int'(stim_a[d]), int'(m_stim[d]));
                check($sformatf("firstfail[%0d]", d), int'(ff_a[d]), int'(m_ff[d]));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m);
        Mode      = m;
        cell_mode = m;
        Start     = 1'b1;
        tick();
        Start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int e;
        e = 0;
        while ((busy_v != 3'b000) && (e < budget)) begin
            tick();
            e++;
        end
        check("wait_idle_in_budget", int'(e < budget), 1);
    endtask

    initial begin
        int e;

        // Reference cell function over every pattern and mode
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 16; s++) begin
                cm_mode = 2'(m);
                cm_stim = 4'(s);
                #1;
                check($sformatf("cell_model m%0d s%0d", m, s), int'(cm_y), int'(golden(2'(m), 4'(s), 4)));
            end
        end
        cm_mode = 2'b10;
        cm_stim = 4'b0000;
        #1;
        check("cell_model nor 0000", int'(cm_y), 1);

        repeat (2) tick();
        check("reset busy", int'(busy_v), 0);
        check("reset done", int'(done_v), 0);
        check("reset pass", int'(pass_v), 0);
        check("reset err4", int'(err_a[2]), 0);
        check("reset stim4", int'(stim4), 0);
        check("reset ff4", int'(ff4), 0);
        Reset  = 1'b0;
        chk_en = 1'b1;

        // INV mode, healthy cells: N_IN=1 finishes 11 edges after Start
        start_run(2'b00);
        e = 0;
        while (!done_v[0] && (e < 200)) begin
            tick();
            e++;
        end
        check("u1 done edge", e, 11);
        check("u1 pass", int'(pass_v[0]), 1);
        check("u1 err", int'(err_a[0]), 0);
        wait_idle(200);

        // NAND mode, N_IN=2 response stuck at 1: only pattern 11 fails
        resp_sel[1] = 1;
        start_run(2'b01);
        wait_idle(200);
        check("u2 nand stuck1 err", int'(err_a[1]), 1);
        check("u2 nand stuck1 ff", int'(ff2), 3);
        check("u2 nand stuck1 pass", int'(pass_v[1]), 0);
        resp_sel[1] = 0;

        // NOR mode, N_IN=4 stuck at 0: only pattern 0000 expects a 1
        resp_sel[2] = 2;
        start_run(2'b10);
        wait_idle(200);
        check("u4 nor stuck0 err", int'(err_a[2]), 1);
        check("u4 nor stuck0 ff", int'(ff4), 0);
        check("u4 nor stuck0 pass", int'(pass_v[2]), 0);

        // XOR mode, N_IN=4 inverted output: every pattern fails
        resp_sel[2] = 3;
        start_run(2'b11);
        wait_idle(200);
        check("u4 xor inv err", int'(err_a[2]), 16);
        check("u4 xor inv ff", int'(ff4), 0);

        // Abort while idle leaves Done standing
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("idle abort keeps done", int'(done_v[2]), 1);

        // Abort in the third settle cycle of pattern 1
        resp_sel[2] = 0;
        start_run(2'b00);
        repeat (7) tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort busy4", int'(busy_v[2]), 0);
        check("abort done4", int'(done_v[2]), 0);
        check("abort stim4", int'(stim4), 1);
        check("abort stim1", int'(stim1), 1);
        repeat (3) tick();

        // Reset during the third sample after two mismatches, then a clean run
        resp_sel[2] = 3;
        start_run(2'b11);
        repeat (14) tick();
        check("pre-reset err4", int'(err_a[2]), 2);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("post-reset busy", int'(busy_v), 0);
        check("post-reset done", int'(done_v), 0);
        check("post-reset pass", int'(pass_v), 0);
        check("post-reset err4", int'(err_a[2]), 0);
        check("post-reset stim4", int'(stim4), 0);
        check("post-reset ff4", int'(ff4), 0);
        resp_sel[2] = 0;
        start_run(2'b11);
        wait_idle(200);
        check("clean after reset pass4", int'(pass_v[2]), 1);
        check("clean after reset err4", int'(err_a[2]), 0);

        // Start+Abort together starts; re-Start and Mode change mid-run are ignored
        Mode      = 2'b01;
        cell_mode = 2'b01;
        Start     = 1'b1;
        Abort     = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        repeat (10) tick();
        Mode  = 2'b10;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        e = 11;
        while (!done_v[2] && (e < 300)) begin
            tick();
            e++;
        end
        check("u4 no restart done edge", e, 81);
        check("u4 latched mode pass", int'(pass_v[2]), 1);
        check("u4 latched mode err", int'(err_a[2]), 0);
        wait_idle(200);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
